// File: rtl/period_meter.sv
// Measures the period of synchronous input si in whole milliseconds (truncated, saturating).
// Define PRD_AVG_EN to average over 2^AVG_LOG2 consecutive periods.
module period_meter #(
  parameter int unsigned CLK_PER_MS = 100_000,
  parameter int unsigned PRD_W      = 10,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             si,
  output logic             ready,
  output logic             done_tick,
  output logic [PRD_W-1:0] prd,
  output logic             ovf
);

  localparam int unsigned T_W = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
`ifdef PRD_AVG_EN
  localparam int unsigned P_W = PRD_W + AVG_LOG2;
  localparam int unsigned E_W = AVG_LOG2 + 1;
  localparam logic [E_W-1:0] E_LAST = E_W'((1 << AVG_LOG2) - 1);
`else
  localparam int unsigned P_W = PRD_W;
`endif
  localparam logic [T_W-1:0] T_LAST = T_W'(CLK_PER_MS - 1);
  localparam logic [P_W-1:0] P_MAX  = '1;

  if (CLK_PER_MS < 2 || AVG_LOG2 > 16) begin : g_bad_param
    $error("period_meter: CLK_PER_MS must be >= 2 and AVG_LOG2 <= 16");
  end

  typedef enum logic [1:0] {IDLE, WAITE, COUNT, DONE} state_e;

  state_e           state_q;
  logic             si_q;
  logic [T_W-1:0]   t_q;
  logic [P_W-1:0]   p_q;
  logic             ovf_int_q;
  logic [PRD_W-1:0] prd_q;
  logic             ovf_q;
  logic             done_q;
  logic             si_edge;
  logic             last_edge;
  logic [PRD_W-1:0] prd_res;

  assign si_edge = si & ~si_q;

`ifdef PRD_AVG_EN
  logic [E_W-1:0] ecnt_q;

  // Edge counter picks the edge that closes the averaging window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ecnt_q <= '0;
    end else if (state_q == WAITE) begin
      ecnt_q <= '0;
    end else if (state_q == COUNT && si_edge) begin
      ecnt_q <= ecnt_q + 1'b1;
    end
  end

  assign last_edge = (ecnt_q == E_LAST);
  assign prd_res   = PRD_W'(p_q >> AVG_LOG2);
`else
  assign last_edge = 1'b1;
  assign prd_res   = p_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      si_q      <= 1'b0;
      t_q       <= '0;
      p_q       <= '0;
      ovf_int_q <= 1'b0;
      prd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      si_q   <= si;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= WAITE;
        end
        WAITE: begin
          // The arming edge cycle already counts as one elapsed cycle.
          if (si_edge) begin
            state_q   <= COUNT;
            t_q       <= T_W'(1);
            p_q       <= '0;
            ovf_int_q <= 1'b0;
          end
        end
        COUNT: begin
          if (si_edge && last_edge) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            prd_q   <= prd_res;
            ovf_q   <= ovf_int_q;
          end else if (t_q == T_LAST) begin
            t_q <= '0;
            if (p_q != P_MAX) p_q <= p_q + 1'b1;
            else              ovf_int_q <= 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = done_q;
  assign prd       = prd_q;
  assign ovf       = ovf_q;

endmodule
